// File: rtl/cla_mp_pkg.sv
// Shared definitions for the multi-precision CLA add sequencer: word width,
// FSM state encoding and the index-width helper.
package cla_mp_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Word-index width; a single-word build still gets a 1-bit counter.
    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cla_mp_add_seq_cla.sv
// 32-bit carry-lookahead adder: 4-bit groups with group generate/propagate
// lookahead across groups.
module cla_mp_add_seq_cla
    import cla_mp_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] s,
    output logic              cout
);

    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] p;
    logic              c_grp;
    logic              c_bit;
    logic              gg;
    logic              gp;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        s     = '0;
        c_grp = cin;
        c_bit = 1'b0;
        gg    = 1'b0;
        gp    = 1'b1;
        for (int grp = 0; grp < WORD_W / 4; grp++) begin
            c_bit = c_grp;
            gg    = 1'b0;
            gp    = 1'b1;
            for (int k = 0; k < 4; k++) begin
                s[grp*4+k] = p[grp*4+k] ^ c_bit;
                c_bit      = g[grp*4+k] | (p[grp*4+k] & c_bit);
                gg         = g[grp*4+k] | (p[grp*4+k] & gg);
                gp         = gp & p[grp*4+k];
            end
            // Group carry-out comes from lookahead terms, not the in-group chain.
            c_grp = gg | (gp & c_grp);
        end
        cout = c_grp;
    end

endmodule

// File: rtl/cla_mp_add_seq.sv
// Multi-precision add sequencer: one 32-bit word pair per cycle through a single
// shared CLA, LSW first. Optional subtract mode under CLA_MP_ADD_SEQ_SUB_EN.
module cla_mp_add_seq
    import cla_mp_pkg::*;
#(
    parameter int NWORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W*NWORDS-1:0] op_a,
    input  logic [WORD_W*NWORDS-1:0] op_b,
    input  logic                     cin,
`ifdef CLA_MP_ADD_SEQ_SUB_EN
    input  logic                     op_sub,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W*NWORDS-1:0] sum,
    output logic                     cout,
    output logic                     busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready is high only in IDLE, out_valid only in DONE.

    localparam int W  = WORD_W * NWORDS;
    localparam int IW = idx_w(NWORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     idx;
    logic              carry_reg;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic [W-1:0]      sum_r;
    logic              cout_r;
`ifdef CLA_MP_ADD_SEQ_SUB_EN
    logic              sub_reg;
`endif

    logic [WORD_W-1:0] cla_a;
    logic [WORD_W-1:0] cla_b;
    logic [WORD_W-1:0] cla_s;
    logic              cla_cin;
    logic              cla_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (idx == LAST_IDX) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // CLA inputs are parked at zero outside RUN so the shared adder stays quiet.
    always_comb begin
        cla_a   = '0;
        cla_b   = '0;
        cla_cin = 1'b0;
        if (state == S_RUN) begin
            cla_a   = a_reg[idx*WORD_W +: WORD_W];
            cla_b   = b_reg[idx*WORD_W +: WORD_W];
`ifdef CLA_MP_ADD_SEQ_SUB_EN
            if (sub_reg) cla_b = ~b_reg[idx*WORD_W +: WORD_W];
`endif
            cla_cin = carry_reg;
        end
    end

    cla_mp_add_seq_cla u_cla (
        .a    (cla_a),
        .b    (cla_b),
        .cin  (cla_cin),
        .s    (cla_s),
        .cout (cla_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_r     <= '0;
            cout_r    <= 1'b0;
`ifdef CLA_MP_ADD_SEQ_SUB_EN
            sub_reg   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg <= op_a;
                        b_reg <= op_b;
                        idx   <= '0;
`ifdef CLA_MP_ADD_SEQ_SUB_EN
                        sub_reg   <= op_sub;
                        carry_reg <= op_sub ? 1'b1 : cin;
`else
                        carry_reg <= cin;
`endif
                    end
                end
                S_RUN: begin
                    sum_r[idx*WORD_W +: WORD_W] <= cla_s;
                    carry_reg                   <= cla_cout;
                    if (idx == LAST_IDX) begin
                        cout_r <= cla_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_cla_mp_add_seq.sv
// Self-checking bench for cla_mp_add_seq (NWORDS=4); subtract cases run when
// CLA_MP_ADD_SEQ_SUB_EN is defined.
module tb_cla_mp_add_seq;

    localparam int NW = 4;
    localparam int W  = 32 * NW;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    logic [W:0]   exp_q[$];
    int           errors = 0;
    int           checks = 0;

    localparam logic [W-1:0] ONES = {W{1'b1}};

    always #5 clk = ~clk;

    cla_mp_add_seq #(.NWORDS(NW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
`ifdef CLA_MP_ADD_SEQ_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + (W+1)'(c);
    endfunction

    // Called just after a falling edge; returns just after the falling edge
    // that follows the accepting rising edge.
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic sub);
        int n;
        op_a     = a;
        op_b     = b;
        cin      = c;
        op_sub   = sub;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 1'b0, 1'b1);
        @(posedge clk);
`ifdef CLA_MP_ADD_SEQ_SUB_EN
        exp_q.push_back(model(a, b, c, sub));
`else
        exp_q.push_back(model(a, b, c, 1'b0));
`endif
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input bit chk_lat);
        int edges;
        logic [W:0] exp;
        edges = 0;
        while (!out_valid && edges < 20) begin
            if (chk_lat) check("in_ready_run", (W+1)'(in_ready), '0);
            @(negedge clk);
            edges++;
        end
        check("out_valid", (W+1)'(out_valid), (W+1)'(1));
        if (chk_lat) begin
            check("latency", (W+1)'(edges), (W+1)'(NW));
            check("in_ready_done", (W+1)'(in_ready), '0);
        end
        if (exp_q.size() == 0) begin
            check("sb_empty", '0, (W+1)'(1));
        end else begin
            exp = exp_q.pop_front();
            check("result", {cout, sum}, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", (W+1)'(out_valid), '0);
        check("in_ready_idle", (W+1)'(in_ready), (W+1)'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0]   held;
        logic [W-1:0] pa;
        logic [W-1:0] pb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        cin       = 1'b0;
        op_sub    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", (W+1)'(in_ready), (W+1)'(1));
        check("rst_out_valid", (W+1)'(out_valid), '0);
        check("rst_busy", (W+1)'(busy), '0);
        check("rst_sum_cout", {cout, sum}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero operands with latency and ready checks.
        drive_op('0, '0, 1'b0, 1'b0);
        check("busy_run", (W+1)'(busy), (W+1)'(1));
        collect(1'b1);

        // Carry propagating through every word.
        drive_op(ONES, 128'd1, 1'b0, 1'b0);
        collect(1'b1);
        drive_op(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0, 1'b0);
        collect(1'b1);
        drive_op(ONES, ONES, 1'b1, 1'b0);
        collect(1'b1);

        // Random operands.
        for (int i = 0; i < 4; i++) begin
            pa = {$urandom, $urandom, $urandom, $urandom};
            pb = {$urandom, $urandom, $urandom, $urandom};
            drive_op(pa, pb, 1'($urandom_range(1, 0)), 1'b0);
            collect(1'b0);
        end

        // Backpressure: result held while new operands are offered and ignored.
        drive_op(128'h1111_2222_3333_4444_5555_6666_7777_8888,
                 128'h8888_7777_6666_5555_4444_3333_2222_1111, 1'b1, 1'b0);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        held = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            in_valid = ((i % 2) == 0);
            op_a     = {$urandom, $urandom, $urandom, $urandom};
            op_b     = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check("bp_out_valid", (W+1)'(out_valid), (W+1)'(1));
            check("bp_result", {cout, sum}, held);
            check("bp_in_ready", (W+1)'(in_ready), '0);
        end
        void'(exp_q.pop_front());
        pa        = 128'h0000_0000_0000_0001_0000_0000_0000_0002;
        pb        = 128'h0000_0000_0000_0003_FFFF_FFFF_FFFF_FFFF;
        op_a      = pa;
        op_b      = pb;
        cin       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", (W+1)'(out_valid), '0);
        check("bp_release_ready", (W+1)'(in_ready), (W+1)'(1));
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_pending_accept", (W+1)'(busy), (W+1)'(1));
        exp_q.push_back(model(pa, pb, 1'b0, 1'b0));
        collect(1'b1);

        // Asynchronous reset in the middle of RUN (idx=2).
        drive_op(ONES, ONES, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", (W+1)'(out_valid), '0);
        check("arst_busy", (W+1)'(busy), '0);
        check("arst_in_ready", (W+1)'(in_ready), (W+1)'(1));
        check("arst_sum_cout", {cout, sum}, '0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_op(128'h1234_5678, 128'h8765_4321, 1'b0, 1'b0);
        collect(1'b1);
        check("arst_low_word", (W+1)'(sum[31:0]), (W+1)'(32'h9999_9999));

`ifdef CLA_MP_ADD_SEQ_SUB_EN
        drive_op(128'd7, 128'd5, 1'b0, 1'b1);
        collect(1'b1);
        drive_op(128'd5, 128'd7, 1'b1, 1'b1);
        collect(1'b1);
        check("sub_borrow_sum", (W+1)'(sum), {1'b0, ONES - 128'd1});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cla_mp_add_seq.md
Name: cla_mp_add_seq

Overview:
Multi-precision add sequencer built around the team's existing 32-bit CLA.
- Accepts two NWORDS×32-bit operands through a valid/ready handshake.
- Feeds one 32-bit word pair per cycle, least-significant word first, into a single CLA instance, chaining the carry through a register.
- Returns the full-width sum and final carry through a second valid/ready handshake.
- Sits between an operand source (register file or test driver) and the shared CLA datapath; it is the only block that drives the CLA's A/B/Cin inputs.

Parameters:
- NWORDS, 4: number of 32-bit words per operand (≥1); total width W = 32*NWORDS.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer can accept; high only in IDLE.
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- cin  input  1  carry into word 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  registered result.
- cout  output  1  carry out of the top word.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, word index=0, carry reg=0, sum=0, cout=0, out_valid=0, busy=0, in_ready=1. Takes effect immediately and discards any in-flight operation.
- States:
  - IDLE: in_ready=1. On a clock edge with in_valid=1:
    - latch op_a, op_b; carry_reg←cin; idx←0; go to RUN.
    - If in_valid=0, stay in IDLE.
  - RUN: CLA.A=a_word[idx], CLA.B=b_word[idx], CLA.Cin=carry_reg (combinational).
    - Each edge: sum word[idx]←CLA.S; carry_reg←CLA.Cout.
    - If idx==NWORDS-1: cout←CLA.Cout; go to DONE. Otherwise idx←idx+1.
  - DONE: out_valid=1; sum and cout held stable. On an edge with out_ready=1, go to IDLE, out_valid←0. Otherwise stay in DONE.
- Latency: out_valid rises exactly NWORDS edges after the accepting edge. Minimum issue interval is NWORDS+2 cycles: the handover from DONE to IDLE costs one bubble, because in_ready is never high in DONE.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- sum words not yet written during RUN hold their previous values; only the value present while out_valid=1 is defined.
- Carry wraps naturally. Overflow beyond W bits is reported only through cout; no saturation.
- NWORDS=1: RUN lasts one cycle.
- The idx counter is $clog2(NWORDS) wide, minimum 1 bit, and never exceeds NWORDS-1.
- When not in RUN, CLA inputs are driven to 0 so the shared CLA does not toggle.

Optional Feature:
- Macro: CLA_MP_ADD_SEQ_SUB_EN.
- Defined:
  - Adds input port op_sub (1 bit), latched with the operands on accept.
  - When op_sub=1, every B word is bit-inverted before it reaches the CLA, and carry_reg is initialised to 1; cin is ignored.
  - The result is A−B mod 2^W. cout=1 means no borrow (A≥B, unsigned).
- Undefined: op_sub port is absent and the block is add-only.

Decomposition:
- Package cla_mp_pkg holds:
  - localparam WORD_W=32;
  - typedef enum {S_IDLE, S_RUN, S_DONE} state_t;
  - function idx_w(n) returning max(1,$clog2(n)).
- No new sub-module. The existing CLA module is instantiated once, and word selection uses an indexed part-select.

Test Plan (NWORDS=4, W=128):
1. A=0, B=0, cin=0 → sum=0, cout=0; out_valid rises exactly 4 edges after accept; in_ready=0 during RUN/DONE.
2. A=all-ones (128'hFFFF…FFFF), B=1, cin=0 → sum=0, cout=1 (carry chains through all four words).
3. A=128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, B=1 → sum=128'h…0001_0000_0000, cout=0. Also: A=B=all-ones, cin=1 → sum=all-ones, cout=1.
4. Backpressure: hold out_ready=0 for 5 cycles while pulsing in_valid with new operands → sum/cout/out_valid stable, new operands not accepted. Raise out_ready → IDLE on the next edge, then the pending operand is accepted on the following edge.
5. Assert rst_n=0 mid-RUN (idx=2) → out_valid=0, busy=0, in_ready=1 immediately, without waiting for a clock edge. After release, A=32'h12345678, B=32'h87654321 (upper words 0) → sum low word 32'h99999999, cout=0.
6. With CLA_MP_ADD_SEQ_SUB_EN: A=7, B=5, op_sub=1 → sum=2, cout=1. A=5, B=7, op_sub=1 → sum=128'hFFFF…FFFE, cout=0.
